multi_key_debounce: RTL

MULTI_KEY_DEBOUNCE -- requirements
Module: multi_key_debounce

---
 rtl/multi_key_debounce.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/multi_key_debounce.sv
// Multi-channel push-button debouncer.
// Each channel synchronizes its raw input and runs a four-state debounce FSM.
// The FSM produces a registered level (key_state) and one-cycle press, release
// and long-press pulses.
module multi_key_debounce #(
  parameter int   N_KEYS          = 5,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   LONG_CYCLES     = 100000000,
  parameter logic PRESS_LEVEL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              key_any
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic          sync_meta, sync_q;
    logic          is_pressed;
    state_t        state, state_nx;
    logic [DW-1:0] deb_cnt, deb_cnt_nx;
    logic [LW-1:0] long_cnt, long_cnt_nx;
    logic          long_done, long_done_nx;
    logic          press_nx, release_nx, long_nx, level_nx;
    logic          level_q, press_q, release_q, long_q;

    assign is_pressed = (sync_q == PRESS_LEVEL);

    // Two-flop synchronizer; it idles at the released level during reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_meta <= ~PRESS_LEVEL;
        sync_q    <= ~PRESS_LEVEL;
      end else begin
        sync_meta <= key[i];
        sync_q    <= sync_meta;
      end
    end

    // State, counters and the registered outputs of this channel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= RELEASED;
        deb_cnt   <= '0;
        long_cnt  <= '0;
        long_done <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state     <= state_nx;
        deb_cnt   <= deb_cnt_nx;
        long_cnt  <= long_cnt_nx;
        long_done <= long_done_nx;
        level_q   <= level_nx;
        press_q   <= press_nx;
        release_q <= release_nx;
        long_q    <= long_nx;
      end
    end

    // Next-state logic. The long-press timer keeps running through a release
    // bounce, so it is handled outside the case and only cleared on a fresh
    // press or when the release is accepted.
    always_comb begin
      state_nx     = state;
      deb_cnt_nx   = deb_cnt;
      long_cnt_nx  = long_cnt;
      long_done_nx = long_done;
      press_nx     = 1'b0;
      release_nx   = 1'b0;
      long_nx      = 1'b0;

      if (state == PRESSED || state == RELEASE_CHK) begin
        if (long_cnt == LONG_MAX) begin
          if (!long_done) begin
            long_nx      = 1'b1;
            long_done_nx = 1'b1;
          end
        end else begin
          long_cnt_nx = long_cnt + LW'(1);
        end
      end

      case (state)
        RELEASED: begin
          long_cnt_nx  = '0;
          long_done_nx = 1'b0;
          if (is_pressed) begin
            state_nx   = PRESS_CHK;
            deb_cnt_nx = '0;
          end
        end
        PRESS_CHK: begin
          if (!is_pressed) begin
            state_nx = RELEASED;
          end else if (deb_cnt == DEB_MAX) begin
            state_nx     = PRESSED;
            press_nx     = 1'b1;
            long_cnt_nx  = '0;
            long_done_nx = 1'b0;
          end else begin
            deb_cnt_nx = deb_cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!is_pressed) begin
            state_nx   = RELEASE_CHK;
            deb_cnt_nx = '0;
          end
        end
        RELEASE_CHK: begin
          if (is_pressed) begin
            state_nx = PRESSED;
          end else if (deb_cnt == DEB_MAX) begin
            state_nx     = RELEASED;
            release_nx   = 1'b1;
            long_cnt_nx  = '0;
            long_done_nx = 1'b0;
          end else begin
            deb_cnt_nx = deb_cnt + DW'(1);
          end
        end
        default: state_nx = RELEASED;
      endcase

      level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_CHK);
    end

    assign key_state[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

  assign key_any = |key_state;

endmodule
